i2c_axi_lite_bridge: RTL and testbench
======================================

Name: i2c_axi_lite_bridge

Overview:
- AXI4-Lite slave front-end for the I2C master subsystem; sits directly upstream of the I2C CSR block.
- Converts AXI4-Lite write/read transactions into single-cycle register strobes (addr/we/re/wdata) and captures read data returned one cycle after the read strobe.
- Independent AW/W/AR holding registers; a round-robin arbiter serialises writes and reads.

Parameters:
P_ADDR_SPAN, 256, decoded byte window; used only when I2C_BRIDGE_DECERR_EN is defined

Ports:
s_axi_aclk  input  1  clock
s_axi_aresetn  input  1  asynchronous active-low reset
s_axi_awaddr  input  32  write address
s_axi_awvalid  input  1  AW valid
s_axi_awready  output  1  AW ready
s_axi_wdata  input  32  write data
s_axi_wvalid  input  1  W valid
s_axi_wready  output  1  W ready
s_axi_bresp  output  2  write response
s_axi_bvalid  output  1  B valid
s_axi_bready  input  1  B ready
s_axi_araddr  input  32  read address
s_axi_arvalid  input  1  AR valid
s_axi_arready  output  1  AR ready
s_axi_rdata  output  32  read data
s_axi_rresp  output  2  read response
s_axi_rvalid  output  1  R valid
s_axi_rready  input  1  R ready
bram_addr  output  32  register address, valid with we/re
bram_wr_data  output  32  write data, valid with we
bram_rd_data  input  32  read data, valid the cycle after re
bram_en  output  1  we | re
bram_we  output  1  one-cycle write strobe
bram_re  output  1  one-cycle read strobe

Behaviour:
- Clock and reset: one clock, s_axi_aclk. Reset s_axi_aresetn is asynchronous, active-low.
- Reset values: all outputs 0. Holding flags aw_full/w_full/ar_full cleared. FSM in IDLE. Arbiter "last" = read.
- Ready signals are derived from registered flags only:
  - awready = ~aw_full
  - wready = ~w_full
  - arready = ~ar_full
- On each handshake, the address or data is latched and its flag set. AW and W may arrive in any order or cycle.
- FSM states: IDLE, WR, WRESP, RD, RCAP, RRESP.
- IDLE arbitration:
  - Write is eligible when aw_full & w_full. Read is eligible when ar_full.
  - If both are eligible, the type opposite to "last" wins. Otherwise the single eligible type is taken.
  - Winner goes to WR or RD.
- WR (1 cycle):
  - bram_we=1, bram_addr=held awaddr, bram_wr_data=held wdata.
  - Clears aw_full and w_full, sets last=write, goes to WRESP.
- WRESP:
  - bvalid=1, bresp=00.
  - On bready: bvalid=0, go to IDLE.
  - New AW/W may be accepted meanwhile.
- RD (1 cycle):
  - bram_re=1, bram_addr=held araddr.
  - Clears ar_full, sets last=read.
- RCAP (1 cycle): registers bram_rd_data into rdata.
- RRESP:
  - rvalid=1, rresp=00; rdata is held stable until rready.
  - On rready: go to IDLE.
- Latency, counted from the handshake edge (cycle 0):
  - Write: we at cycle 1, bvalid from cycle 2.
  - Read: re at cycle 1, rvalid from cycle 3.
  - With bready/rready held high, a new same-type transaction can be strobed every 3 cycles (write) or 4 cycles (read).
- Only one transaction is outstanding toward the register side. bram_we and bram_re are never high together.
- bvalid/rvalid stall indefinitely with bready/rready low. No strobes issue during a stall.
- bram_addr holds its last value when no strobe is active.
- Reset mid-transaction: the transaction is dropped, no response is issued, all outputs return to 0 immediately.

Optional Feature:
- Macro I2C_BRIDGE_DECERR_EN.
- Defined:
  - Write with held awaddr >= P_ADDR_SPAN: WR issues no bram_we, bresp=10 (SLVERR).
  - Read with held araddr >= P_ADDR_SPAN: RD issues no bram_re, rdata=0, rresp=10.
  - Latency is unchanged.
- Not defined: every address is forwarded and responses are always 00.

Test Plan:
- Write 0x8 / 0xA5A5_0001, AW and W same cycle, bready=1 -> bram_we pulse at cycle 1 with addr 0x8 and data 0xA5A5_0001; bvalid at cycle 2 with bresp=00.
- W presented 3 cycles before AW (addr 0x10, data 0x55) -> wready drops after the W handshake; strobe occurs only after AW arrives; exactly one bram_we.
- Read 0x4, bram_rd_data=0x1234 in the cycle after re -> rvalid at cycle 3, rdata=0x1234; rready held low 5 cycles -> rdata stable, no further re.
- Complete write and read pending simultaneously with last=read -> write strobed first, then read; the repeated case alternates write, read, write, read.
- Assert aresetn low in RCAP -> all outputs 0 asynchronously; after release, no rvalid and arready=1.
- With I2C_BRIDGE_DECERR_EN and P_ADDR_SPAN=256: write to 0x100 -> no bram_we, bresp=10; read 0x100 -> no bram_re, rdata=0, rresp=10; read 0xFC -> normal, rresp=00.

Source files
------------

// File: rtl/i2c_axi_lite_bridge.sv
// ---------------------------------------------------------------------------
// i2c_axi_lite_bridge
//
// Purpose:
//   AXI4-Lite slave front-end for the I2C CSR block. The bridge turns AXI
//   writes and reads into one-cycle register strobes (bram_we / bram_re). It
//   captures read data that the register side returns one cycle after
//   bram_re. AW, W and AR each have their own holding register. A two-way
//   round-robin arbiter lets only one transaction at a time reach the
//   register side.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn     clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*               AXI4-Lite write address / data / response
//   s_axi_ar*/r*                  AXI4-Lite read address / data
//   bram_addr, bram_wr_data       register address and write data
//   bram_rd_data                  read data, valid the cycle after bram_re
//   bram_en, bram_we, bram_re     register strobes (we and re never overlap)
//
// Build option:
//   I2C_BRIDGE_DECERR_EN - when defined, an address >= P_ADDR_SPAN gets no
//   strobe and is answered with SLVERR (2'b10). A read of such an address
//   returns zero data.
// ---------------------------------------------------------------------------
module i2c_axi_lite_bridge #(
  parameter int unsigned P_ADDR_SPAN = 256
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wr_data,
  input  logic [31:0] bram_rd_data,
  output logic        bram_en,
  output logic        bram_we,
  output logic        bram_re
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD,
    S_RCAP,
    S_RRESP
  } state_t;

  state_t      state_q, state_d;
  logic        aw_full_q, aw_full_d;
  logic        w_full_q, w_full_d;
  logic        ar_full_q, ar_full_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] araddr_q, araddr_d;
  logic        last_rd_q, last_rd_d;   // 1: last granted transaction was a read
  logic        err_q, err_d;           // current transaction is out of window
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rdata_q, rdata_d;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_elig, rd_elig;
  logic        wr_err, rd_err;

`ifdef I2C_BRIDGE_DECERR_EN
  assign wr_err = (awaddr_q >= 32'(P_ADDR_SPAN));
  assign rd_err = (araddr_q >= 32'(P_ADDR_SPAN));
`else
  // The window size only matters when decode errors are enabled.
  logic [31:0] span_unused;
  assign span_unused = 32'(P_ADDR_SPAN);
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // The ready outputs come only from the holding flags. They are also gated
  // with reset so that every output reads 0 while reset is asserted.
  assign s_axi_awready = ~aw_full_q & s_axi_aresetn;
  assign s_axi_wready  = ~w_full_q & s_axi_aresetn;
  assign s_axi_arready = ~ar_full_q & s_axi_aresetn;

  assign aw_hs = s_axi_awvalid & ~aw_full_q;
  assign w_hs  = s_axi_wvalid & ~w_full_q;
  assign ar_hs = s_axi_arvalid & ~ar_full_q;

  assign wr_elig = aw_full_q & w_full_q;
  assign rd_elig = ar_full_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= S_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      last_rd_q <= 1'b1;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      last_rd_q <= last_rd_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    last_rd_d = last_rd_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;

    // The holding registers accept new requests in every state. A flag is
    // never cleared in the same cycle as a handshake on that channel,
    // because the ready signal is low while the flag is set.
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi_wdata;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      araddr_d  = s_axi_araddr;
    end

    unique case (state_q)
      S_IDLE: begin
        // If both requests are ready, the type that did not go last wins.
        if (wr_elig && (!rd_elig || last_rd_q)) begin
          state_d = S_WR;
          err_d   = wr_err;
          // The address and write data are loaded only when a strobe will
          // actually be issued, so bram_addr keeps the last real address.
          if (!wr_err) begin
            addr_d    = awaddr_q;
            wr_data_d = wdata_q;
          end
        end else if (rd_elig) begin
          state_d = S_RD;
          err_d   = rd_err;
          if (!rd_err) begin
            addr_d = araddr_q;
          end
        end
      end
      S_WR: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        last_rd_d = 1'b0;
        state_d   = S_WRESP;
      end
      S_WRESP: begin
        if (s_axi_bready) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        ar_full_d = 1'b0;
        last_rd_d = 1'b1;
        state_d   = S_RCAP;
      end
      S_RCAP: begin
        rdata_d = err_q ? 32'h0 : bram_rd_data;
        state_d = S_RRESP;
      end
      S_RRESP: begin
        if (s_axi_rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bram_we      = (state_q == S_WR) & ~err_q;
  assign bram_re      = (state_q == S_RD) & ~err_q;
  assign bram_en      = bram_we | bram_re;
  assign bram_addr    = addr_q;
  assign bram_wr_data = wr_data_q;

  assign s_axi_bvalid = (state_q == S_WRESP);
  assign s_axi_bresp  = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_rvalid = (state_q == S_RRESP);
  assign s_axi_rresp  = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_i2c_axi_lite_bridge.sv
// ---------------------------------------------------------------------------
// tb_i2c_axi_lite_bridge
//
// Directed testbench for i2c_axi_lite_bridge. Inputs change on the falling
// clock edge and outputs are sampled on the falling edge. "Cycle n" is the
// clock period after rising edge n, and edge 0 is the AXI handshake edge.
// Compile with +define+I2C_BRIDGE_DECERR_EN to run the decode-error tests.
// ---------------------------------------------------------------------------
module tb_i2c_axi_lite_bridge;

  logic        clk;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] bram_addr;
  logic [31:0] bram_wr_data;
  logic [31:0] bram_rd_data;
  logic        bram_en;
  logic        bram_we;
  logic        bram_re;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int overlap  = 0;
  byte seq[$];

  i2c_axi_lite_bridge #(.P_ADDR_SPAN(256)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(aresetn),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_data (bram_rd_data),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_re      (bram_re)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor. It samples the values from the cycle that ends at this
  // edge.
  always @(posedge clk) begin
    if (bram_we) begin
      we_cnt <= we_cnt + 1;
      seq.push_back(8'h57);
    end
    if (bram_re) begin
      re_cnt <= re_cnt + 1;
      seq.push_back(8'h52);
    end
    if (bram_we && bram_re) overlap <= overlap + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step(2);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, bram_en, bram_we, bram_re} !== 5'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 00000", {bvalid, rvalid, bram_en, bram_we, bram_re});
    end
    checks++;
    if ({bram_addr, bram_wr_data, rdata, bresp, rresp} !== 100'h0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0", bram_addr, bram_wr_data, rdata);
    end
    aresetn = 1'b1;
    step(1);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++;
      $display("FAIL post_reset_ready: got %b expected 111", {awready, wready, arready});
    end
    $display("test_reset done");
  endtask

  task automatic test_write_basic();
    bready  = 1'b1;
    awaddr  = 32'h8;
    wdata   = 32'hA5A5_0001;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    step(1);                       // edge 0 handshake -> cycle 0
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checks++;
    if ({awready, wready, bram_we} !== 3'b000) begin
      failures++;
      $display("FAIL wr_cycle0: got awready/wready/we=%b expected 000", {awready, wready, bram_we});
    end
    step(1);                       // cycle 1
    checks++;
    if ({bram_we, bram_en, bram_re} !== 3'b110) begin
      failures++;
      $display("FAIL wr_strobe: got we/en/re=%b expected 110", {bram_we, bram_en, bram_re});
    end
    checks++;
    if (bram_addr !== 32'h8 || bram_wr_data !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL wr_addr_data: got %h/%h expected 00000008/a5a50001", bram_addr, bram_wr_data);
    end
    step(1);                       // cycle 2
    checks++;
    if ({bvalid, bresp, bram_we} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_bresp: got bvalid=%b bresp=%b we=%b expected 1/00/0", bvalid, bresp, bram_we);
    end
    step(1);                       // cycle 3, B accepted at edge 3
    checks++;
    if (bvalid !== 1'b0 || bram_addr !== 32'h8) begin
      failures++;
      $display("FAIL wr_done: got bvalid=%b addr=%h expected 0/00000008", bvalid, bram_addr);
    end
    $display("test_write_basic done");
  endtask

  task automatic test_w_before_aw();
    int snap;
    snap   = we_cnt;
    wdata  = 32'h55;
    wvalid = 1'b1;
    step(1);
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      failures++;
      $display("FAIL w_first_ready: got wready=%b awready=%b expected 0/1", wready, awready);
    end
    step(3);
    checks++;
    if (we_cnt !== snap || wready !== 1'b0) begin
      failures++;
      $display("FAIL w_first_nostrobe: got we_cnt=%0d wready=%b expected %0d/0", we_cnt, wready, snap);
    end
    awaddr  = 32'h10;
    awvalid = 1'b1;
    step(1);
    awvalid = 1'b0;
    step(1);                       // cycle 1 after AW
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== 32'h10 || bram_wr_data !== 32'h55) begin
      failures++;
      $display("FAIL w_first_strobe: got we=%b addr=%h data=%h expected 1/00000010/00000055", bram_we, bram_addr, bram_wr_data);
    end
    step(2);
    checks++;
    if (we_cnt !== snap + 1) begin
      failures++;
      $display("FAIL w_first_count: got %0d expected %0d", we_cnt, snap + 1);
    end
    $display("test_w_before_aw done");
  endtask

  task automatic test_read_stall();
    int snap;
    rready  = 1'b0;
    araddr  = 32'h4;
    arvalid = 1'b1;
    bram_rd_data = 32'hBAD0_BAD0;
    step(1);                       // edge 0 -> cycle 0
    arvalid = 1'b0;
    step(1);                       // cycle 1
    checks++;
    if (bram_re !== 1'b1 || bram_en !== 1'b1 || bram_addr !== 32'h4) begin
      failures++;
      $display("FAIL rd_strobe: got re=%b en=%b addr=%h expected 1/1/00000004", bram_re, bram_en, bram_addr);
    end
    bram_rd_data = 32'h1234;       // valid through cycle 2
    step(1);                       // cycle 2
    checks++;
    if (rvalid !== 1'b0 || bram_re !== 1'b0) begin
      failures++;
      $display("FAIL rd_cycle2: got rvalid=%b re=%b expected 0/0", rvalid, bram_re);
    end
    step(1);                       // cycle 3
    bram_rd_data = 32'hDEAD_BEEF;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234 || rresp !== 2'b00) begin
      failures++;
      $display("FAIL rd_rvalid: got rvalid=%b rdata=%h rresp=%b expected 1/00001234/00", rvalid, rdata, rresp);
    end
    snap = re_cnt;
    step(5);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234 || re_cnt !== snap) begin
      failures++;
      $display("FAIL rd_stall: got rvalid=%b rdata=%h re_cnt=%0d expected 1/00001234/%0d", rvalid, rdata, re_cnt, snap);
    end
    rready = 1'b1;
    step(1);
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_release: got rvalid=%b expected 0", rvalid);
    end
    $display("test_read_stall done");
  endtask

  task automatic test_arbitration();
    // The previous transaction was a read, so the write must win.
    awaddr  = 32'h20;
    wdata   = 32'h99;
    araddr  = 32'h24;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    arvalid = 1'b1;
    step(1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    step(1);                       // cycle 1
    checks++;
    if (bram_we !== 1'b1 || bram_re !== 1'b0 || bram_addr !== 32'h20) begin
      failures++;
      $display("FAIL arb_write_first: got we=%b re=%b addr=%h expected 1/0/00000020", bram_we, bram_re, bram_addr);
    end
    step(3);                       // cycle 4: WRESP at 2, IDLE at 3, RD at 4
    checks++;
    if (bram_re !== 1'b1 || bram_addr !== 32'h24) begin
      failures++;
      $display("FAIL arb_read_second: got re=%b addr=%h expected 1/00000024", bram_re, bram_addr);
    end
    step(4);

    // Keep all channels requesting; the grants must alternate.
    seq.delete();
    awaddr  = 32'h30;
    wdata   = 32'h77;
    araddr  = 32'h34;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    arvalid = 1'b1;
    step(20);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    step(20);
    checks++;
    if (seq.size() < 4) begin
      failures++;
      $display("FAIL arb_alt_len: got %0d strobes expected at least 4", seq.size());
    end else if (seq[0] !== 8'h57 || seq[1] !== 8'h52 || seq[2] !== 8'h57 || seq[3] !== 8'h52) begin
      failures++;
      $display("FAIL arb_alt_order: got %c%c%c%c expected WRWR", seq[0], seq[1], seq[2], seq[3]);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL we_re_overlap: got %0d expected 0", overlap);
    end
    $display("test_arbitration done");
  endtask

  task automatic test_reset_mid();
    int snap;
    rready  = 1'b0;
    araddr  = 32'h40;
    arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(2);                       // cycle 2 = RCAP
    aresetn = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bram_en, bram_we, bram_re} !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_ctrl: got %b expected 00000000", {awready, wready, arready, bvalid, rvalid, bram_en, bram_we, bram_re});
    end
    checks++;
    if ({bram_addr, bram_wr_data, rdata, rresp} !== 98'h0) begin
      failures++;
      $display("FAIL rst_mid_data: addr=%h wdata=%h rdata=%h rresp=%b expected all 0", bram_addr, bram_wr_data, rdata, rresp);
    end
    snap = re_cnt;
    step(1);
    aresetn = 1'b1;
    step(4);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || re_cnt !== snap) begin
      failures++;
      $display("FAIL rst_mid_after: got rvalid=%b arready=%b re_cnt=%0d expected 0/1/%0d", rvalid, arready, re_cnt, snap);
    end
    rready = 1'b1;
    $display("test_reset_mid done");
  endtask

`ifdef I2C_BRIDGE_DECERR_EN
  task automatic test_decerr();
    int snap;
    snap    = we_cnt;
    awaddr  = 32'h100;
    wdata   = 32'h1;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    step(1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    step(1);
    checks++;
    if (bram_we !== 1'b0 || bram_en !== 1'b0) begin
      failures++;
      $display("FAIL decerr_wr_strobe: got we=%b en=%b expected 0/0", bram_we, bram_en);
    end
    step(1);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || we_cnt !== snap) begin
      failures++;
      $display("FAIL decerr_bresp: got bvalid=%b bresp=%b we_cnt=%0d expected 1/10/%0d", bvalid, bresp, we_cnt, snap);
    end
    step(2);
    bram_rd_data = 32'hFFFF_FFFF;
    araddr  = 32'h100;
    arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(1);
    checks++;
    if (bram_re !== 1'b0) begin
      failures++;
      $display("FAIL decerr_rd_strobe: got re=%b expected 0", bram_re);
    end
    step(2);
    checks++;
    if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL decerr_rresp: got rvalid=%b rresp=%b rdata=%h expected 1/10/00000000", rvalid, rresp, rdata);
    end
    step(2);
    bram_rd_data = 32'hCAFE;
    araddr  = 32'hFC;
    arvalid = 1'b1;
    step(1);
    arvalid = 1'b0;
    step(1);
    checks++;
    if (bram_re !== 1'b1 || bram_addr !== 32'hFC) begin
      failures++;
      $display("FAIL inwin_rd_strobe: got re=%b addr=%h expected 1/000000fc", bram_re, bram_addr);
    end
    step(2);
    checks++;
    if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'hCAFE) begin
      failures++;
      $display("FAIL inwin_rresp: got rvalid=%b rresp=%b rdata=%h expected 1/00/0000cafe", rvalid, rresp, rdata);
    end
    step(2);
    $display("test_decerr done");
  endtask
`else
  task automatic test_no_decerr();
    awaddr  = 32'h100;
    wdata   = 32'h1;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    step(1);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    step(1);
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== 32'h100) begin
      failures++;
      $display("FAIL nodec_wr_strobe: got we=%b addr=%h expected 1/00000100", bram_we, bram_addr);
    end
    step(1);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL nodec_bresp: got bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
    end
    step(2);
    $display("test_no_decerr done");
  endtask
`endif

  initial begin
    aresetn      = 1'b0;
    awaddr       = '0;
    awvalid      = 1'b0;
    wdata        = '0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    araddr       = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    bram_rd_data = '0;

    test_reset();
    test_write_basic();
    test_w_before_aw();
    test_read_stall();
    test_arbitration();
    test_reset_mid();
`ifdef I2C_BRIDGE_DECERR_EN
    test_decerr();
`else
    test_no_decerr();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
